// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: pc control, program memory data, redirect and decode handshake
interface fetch_stage_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]  pc_addr;
    logic [INSTR_WIDTH-1:0] mem_dout;
    logic                   pc_inc;
    logic                   pc_jmp;
    logic [ADDR_WIDTH-1:0]  pc_addrin;
    logic                   br_req;
    logic [ADDR_WIDTH-1:0]  br_target;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic                   instr_valid;
    logic                   instr_ready;

    // Fetch stage side
    modport master (
        input  pc_addr, mem_dout, br_req, br_target, instr_ready,
        output pc_inc, pc_jmp, pc_addrin, instr, instr_pc, instr_valid
    );

    // Environment side: pc, program memory, decode/execute
    modport slave (
        output pc_addr, mem_dout, br_req, br_target, instr_ready,
        input  pc_inc, pc_jmp, pc_addrin, instr, instr_pc, instr_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with one-cycle memory latency tracking and 2-entry output queue
module fetch_stage #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    fetch_stage_if.master bus
);

    logic [1:0]             count_q, count_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   inflight_vld_q, inflight_vld_d;
    logic [ADDR_WIDTH-1:0]  inflight_pc_q, inflight_pc_d;
    logic [INSTR_WIDTH-1:0] fifo_instr_q [2];
    logic [ADDR_WIDTH-1:0]  fifo_pc_q    [2];

    logic       redirect;
    logic       has_data;
    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] credit;

    // Redirect is meaningless while the block is being reset
    assign redirect = bus.br_req && !rst;
    assign has_data = (count_q != 2'd0) && !rst;

    // Slots committed after this edge: buffered words, minus the one leaving, plus the one in flight.
    // The instr_ready -> pc_inc path is deliberate so a draining queue keeps issuing every cycle.
    assign pop    = bus.instr_valid && bus.instr_ready;
    assign credit = {1'b0, count_q} + {2'b00, inflight_vld_q} - {2'b00, pop};
    assign issue  = en && !redirect && !rst && (credit < 3'd2);

    // A word returning from a pre-redirect read is dropped
    assign push = inflight_vld_q && !redirect;

    assign bus.pc_inc      = issue;
    assign bus.pc_jmp      = redirect;
    assign bus.pc_addrin   = redirect ? bus.br_target : '0;
    assign bus.instr_valid = has_data && !redirect;
    assign bus.instr       = has_data ? fifo_instr_q[rd_ptr_q] : '0;
    assign bus.instr_pc    = has_data ? fifo_pc_q[rd_ptr_q]    : '0;

    // Next-state for queue bookkeeping and the in-flight read tracker
    always_comb begin
        count_d        = count_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        inflight_vld_d = issue;
        inflight_pc_d  = issue ? bus.pc_addr : inflight_pc_q;
        if (redirect) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
            rd_ptr_d = rd_ptr_q ^ pop;
            wr_ptr_d = wr_ptr_q ^ push;
        end
    end

    // State registers; reset discards both queued and in-flight words
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q        <= 2'd0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            inflight_vld_q <= 1'b0;
            inflight_pc_q  <= '0;
        end else begin
            count_q        <= count_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            inflight_vld_q <= inflight_vld_d;
            inflight_pc_q  <= inflight_pc_d;
        end
    end

    // Queue storage: capture memory data with the address it was read from
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_instr_q[0] <= '0;
            fifo_instr_q[1] <= '0;
            fifo_pc_q[0]    <= '0;
            fifo_pc_q[1]    <= '0;
        end else if (push) begin
            fifo_instr_q[wr_ptr_q] <= bus.mem_dout;
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with pc and program memory models
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst;
    logic en;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [7:0] exp_q [$];
    logic [7:0] pc_q;

    fetch_stage_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(16)) bif ();

    fetch_stage #(.ADDR_WIDTH(8), .INSTR_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bif)
    );

    always #5 clk = ~clk;

    // pc module model: reset to 0, jump has priority over increment, 8-bit wrap
    always @(posedge clk) begin
        if (rst)             pc_q <= 8'h00;
        else if (bif.pc_jmp) pc_q <= bif.pc_addrin;
        else if (bif.pc_inc) pc_q <= pc_q + 8'h01;
    end
    assign bif.pc_addr = pc_q;

    // Program memory model: M[a] = {A5, a}, one-cycle read latency
    always @(posedge clk) bif.mem_dout <= {8'hA5, pc_q};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [7:0] first, input int n);
        logic [7:0] a;
        a = first;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + 8'h01;
        end
    endtask

    // Monitor: every transfer to decode must match the next expected word
    always @(negedge clk) begin
        logic [7:0] e;
        if (bif.instr_valid && bif.instr_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", {24'h0, bif.instr_pc}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_instr_pc", {24'h0, bif.instr_pc}, {24'h0, e});
                check("sb_instr", {16'h0, bif.instr}, {16'h0, 8'hA5, e});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1;
        bif.br_req = 1'b1; bif.br_target = 8'h55; bif.instr_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("rst_pc_inc", {31'h0, bif.pc_inc}, 32'h0);
        check("rst_pc_jmp", {31'h0, bif.pc_jmp}, 32'h0);
        check("rst_pc_addrin", {24'h0, bif.pc_addrin}, 32'h0);
        check("rst_instr_valid", {31'h0, bif.instr_valid}, 32'h0);
        check("rst_instr", {16'h0, bif.instr}, 32'h0);
        check("rst_instr_pc", {24'h0, bif.instr_pc}, 32'h0);

        // cycle 0: stream 0x00..0x2F
        tick(); rst = 1'b0; bif.br_req = 1'b0; bif.br_target = 8'h00; bif.instr_ready = 1'b1;
        push_range(8'h00, 48);
        @(negedge clk);
        check("first_pc_inc", {31'h0, bif.pc_inc}, 32'h1);
        check("first_valid_c0", {31'h0, bif.instr_valid}, 32'h0);
        tick(); @(negedge clk);
        check("first_valid_c1", {31'h0, bif.instr_valid}, 32'h0);
        tick(); @(negedge clk);
        check("first_valid_c2", {31'h0, bif.instr_valid}, 32'h1);
        check("first_instr_pc", {24'h0, bif.instr_pc}, 32'h0);
        repeat (47) tick();

        // cycle 50: backpressure for 5 cycles, head is 0x30
        tick(); bif.instr_ready = 1'b0;
        push_range(8'h30, 8);
        @(negedge clk);
        check("bp_pc_inc_c50", {31'h0, bif.pc_inc}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(); @(negedge clk);
            check("bp_pc_inc", {31'h0, bif.pc_inc}, 32'h0);
            check("bp_valid", {31'h0, bif.instr_valid}, 32'h1);
            check("bp_instr_pc", {24'h0, bif.instr_pc}, 32'h30);
            check("bp_instr", {16'h0, bif.instr}, 32'hA530);
        end
        tick(); bif.instr_ready = 1'b1;
        repeat (7) tick();

        // cycle 63: redirect to 0x03 while streaming
        tick(); bif.br_req = 1'b1; bif.br_target = 8'h03;
        push_range(8'h03, 5);
        @(negedge clk);
        check("br_pc_jmp", {31'h0, bif.pc_jmp}, 32'h1);
        check("br_pc_addrin", {24'h0, bif.pc_addrin}, 32'h03);
        check("br_valid", {31'h0, bif.instr_valid}, 32'h0);
        check("br_pc_inc", {31'h0, bif.pc_inc}, 32'h0);
        tick(); bif.br_req = 1'b0; bif.br_target = 8'h00;
        @(negedge clk);
        check("br1_pc_jmp", {31'h0, bif.pc_jmp}, 32'h0);
        check("br1_pc_addrin", {24'h0, bif.pc_addrin}, 32'h0);
        check("br1_pc_inc", {31'h0, bif.pc_inc}, 32'h1);
        check("br1_valid", {31'h0, bif.instr_valid}, 32'h0);
        tick(); @(negedge clk);
        check("br2_valid", {31'h0, bif.instr_valid}, 32'h0);
        tick(); @(negedge clk);
        check("br3_valid", {31'h0, bif.instr_valid}, 32'h1);
        check("br3_instr_pc", {24'h0, bif.instr_pc}, 32'h03);
        repeat (4) tick();

        // cycle 71: fill queue, then redirect to 0x40 while stalled
        tick(); bif.instr_ready = 1'b0;
        tick(); @(negedge clk);
        check("full_pc_inc", {31'h0, bif.pc_inc}, 32'h0);
        check("full_instr_pc", {24'h0, bif.instr_pc}, 32'h08);
        tick(); bif.br_req = 1'b1; bif.br_target = 8'h40;
        push_range(8'h40, 2);
        @(negedge clk);
        check("stall_br_pc_jmp", {31'h0, bif.pc_jmp}, 32'h1);
        check("stall_br_valid", {31'h0, bif.instr_valid}, 32'h0);
        tick(); bif.br_req = 1'b0; bif.instr_ready = 1'b1;
        tick();
        tick(); @(negedge clk);
        check("stall_br_head", {24'h0, bif.instr_pc}, 32'h40);
        tick();

        // cycle 78: redirect to 0xFE, then enable low for 3 cycles
        tick(); bif.br_req = 1'b1; bif.br_target = 8'hFE;
        push_range(8'hFE, 4);
        tick(); bif.br_req = 1'b0; bif.br_target = 8'h00;
        tick(); en = 1'b0;
        @(negedge clk);
        check("en_lo_pc_inc0", {31'h0, bif.pc_inc}, 32'h0);
        tick(); @(negedge clk);
        check("en_lo_pc_inc1", {31'h0, bif.pc_inc}, 32'h0);
        check("en_lo_inflight", {24'h0, bif.instr_pc}, 32'hFE);
        tick(); @(negedge clk);
        check("en_lo_pc_inc2", {31'h0, bif.pc_inc}, 32'h0);
        tick(); en = 1'b1;
        repeat (4) tick();

        // cycle 88: buffer 2 words, then reset mid-operation
        tick(); bif.instr_ready = 1'b0;
        tick(); rst = 1'b1;
        tick(); @(negedge clk);
        check("mid_rst_valid", {31'h0, bif.instr_valid}, 32'h0);
        check("mid_rst_instr", {16'h0, bif.instr}, 32'h0);
        check("mid_rst_instr_pc", {24'h0, bif.instr_pc}, 32'h0);
        check("mid_rst_pc_inc", {31'h0, bif.pc_inc}, 32'h0);
        push_range(8'h00, 3);
        tick(); rst = 1'b0; bif.instr_ready = 1'b1;
        @(negedge clk);
        check("restart_pc_inc", {31'h0, bif.pc_inc}, 32'h1);
        repeat (4) tick();
        tick(); bif.instr_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("sb_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
